fp_mul_seq: RTL and testbench

Iterative single-precision multiplier controller that sequences a radix-2 shift-add mantissa datapath behind a valid/ready handshake. It sits between the FPU issue logic and the result bus and owns operand capture, special-case detection, the 24-step mantissa multiply, normalization, rounding and flag generation. It uses the same flush-to-zero policy as the combinational multiplier: subnormal inputs are zero and no subnormal results are produced.

---
 rtl/fp_mul_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Iterative binary32 multiplier: captures operands, resolves specials, runs a
// 24-step radix-2 shift-add mantissa multiply, then normalizes, rounds and flags.
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        busy
);

    localparam int unsigned FrcW = 23;
    localparam int unsigned SigW = 24;
    localparam int unsigned AccW = 48;
    localparam int unsigned ExpW = 10;
    localparam int unsigned CntW = 5;

    localparam logic [30:0] MagInf    = 31'h7F80_0000;
    localparam logic [30:0] MagMaxFin = 31'h7F7F_FFFF;
    localparam logic [31:0] QNan      = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [31:0]            x_q;
    logic [31:0]            y_q;
    logic [2:0]             mode_q;
    logic                   sign_q;
    logic [AccW-1:0]        acc_q;
    logic [SigW-1:0]        mcand_q;
    logic [SigW-1:0]        mplier_q;
    logic signed [ExpW-1:0] exp_q;
    logic [CntW-1:0]        cnt_q;
    logic [FrcW-1:0]        mant_q;
    logic                   g_q;
    logic                   s_q;
    logic [31:0]            z_q;
    logic                   ovrf_q;
    logic                   udrf_q;
    logic                   out_valid_q;

    // Operand classification (exponent 0 is zero regardless of fraction)
    logic [7:0] ex_c, ey_c;
    logic       x_zero_c, y_zero_c, x_inf_c, y_inf_c, x_nan_c, y_nan_c;
    logic       sign_c;
    logic       special_c;
    logic [31:0] special_z_c;
    logic signed [ExpW-1:0] exp_sum_c;

    always_comb begin
        ex_c        = x_q[30:23];
        ey_c        = y_q[30:23];
        x_zero_c    = (ex_c == 8'h00);
        y_zero_c    = (ey_c == 8'h00);
        x_inf_c     = (ex_c == 8'hFF) && (x_q[22:0] == 23'd0);
        y_inf_c     = (ey_c == 8'hFF) && (y_q[22:0] == 23'd0);
        x_nan_c     = (ex_c == 8'hFF) && (x_q[22:0] != 23'd0);
        y_nan_c     = (ey_c == 8'hFF) && (y_q[22:0] != 23'd0);
        sign_c      = x_q[31] ^ y_q[31];
        special_c   = 1'b1;
        special_z_c = 32'd0;
        if (x_nan_c || y_nan_c) begin
            special_z_c = QNan;
        end else if ((x_inf_c || y_inf_c) && (x_zero_c || y_zero_c)) begin
            special_z_c = QNan;
        end else if (x_inf_c || y_inf_c) begin
            special_z_c = {sign_c, MagInf};
        end else if (x_zero_c || y_zero_c) begin
            special_z_c = {sign_c, 31'd0};
        end else begin
            special_c   = 1'b0;
        end
        exp_sum_c = ExpW'({2'b00, ex_c}) + ExpW'({2'b00, ey_c}) - ExpW'(10'd127);
    end

    // Rounding increment, carry handling and post-round range check
    logic                   inc_c;
    logic [SigW-1:0]        mant_sum_c;
    logic [FrcW-1:0]        rmant_c;
    logic signed [ExpW-1:0] rexp_c;
    logic                   ovf_c;
    logic                   unf_c;
    logic                   ovf_inf_c;
    logic [31:0]            round_z_c;

    always_comb begin
        inc_c     = 1'b0;
        ovf_inf_c = 1'b1;
        case (mode_q)
            3'b001: begin
                inc_c     = 1'b0;
                ovf_inf_c = 1'b0;
            end
            3'b010: begin
                inc_c     = sign_q & (g_q | s_q);
                ovf_inf_c = sign_q;
            end
            3'b011: begin
                inc_c     = ~sign_q & (g_q | s_q);
                ovf_inf_c = ~sign_q;
            end
            3'b100: begin
                inc_c     = g_q;
                ovf_inf_c = 1'b1;
            end
            default: begin
                inc_c     = g_q & (s_q | mant_q[0]);
                ovf_inf_c = 1'b1;
            end
        endcase
        mant_sum_c = {1'b0, mant_q} + SigW'(inc_c);
        rmant_c    = mant_sum_c[SigW-1] ? FrcW'(0) : mant_sum_c[FrcW-1:0];
        rexp_c     = exp_q + (mant_sum_c[SigW-1] ? ExpW'(1) : ExpW'(0));
        ovf_c      = (rexp_c >= 10'sd255);
        unf_c      = (rexp_c <= 10'sd0);
        if (ovf_c) begin
            round_z_c = {sign_q, ovf_inf_c ? MagInf : MagMaxFin};
        end else if (unf_c) begin
            round_z_c = {sign_q, 31'd0};
        end else begin
            round_z_c = {sign_q, rexp_c[7:0], rmant_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            mant_q      <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            z_q         <= '0;
            ovrf_q      <= 1'b0;
            udrf_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q     <= fp_X;
                        y_q     <= fp_Y;
                        mode_q  <= r_mode;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q <= sign_c;
                    if (special_c) begin
                        z_q         <= special_z_c;
                        ovrf_q      <= 1'b0;
                        udrf_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        acc_q    <= '0;
                        mcand_q  <= {1'b1, x_q[22:0]};
                        mplier_q <= {1'b1, y_q[22:0]};
                        exp_q    <= exp_sum_c;
                        cnt_q    <= '0;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + (AccW'(mcand_q) << cnt_q);
                    end
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(SigW - 1)) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (acc_q[AccW-1]) begin
                        mant_q <= acc_q[46:24];
                        g_q    <= acc_q[23];
                        s_q    <= |acc_q[22:0];
                        exp_q  <= exp_q + ExpW'(1);
                    end else begin
                        mant_q <= acc_q[45:23];
                        g_q    <= acc_q[22];
                        s_q    <= |acc_q[21:0];
                    end
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    z_q         <= round_z_c;
                    ovrf_q      <= ovf_c;
                    udrf_q      <= unf_c;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign fp_Z      = z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed cases, random operands against an exact
// integer-product reference, handshake hold and mid-multiply reset.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_X = '0;
    logic [31:0] fp_Y = '0;
    logic [2:0]  r_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    endfunction

    // Reference: exact 48-bit significand product, rounded by comparing the
    // discarded remainder against one half ulp. Returns {ovrf, udrf, z}.
    function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] mode);
        int          ex, ey, e, sh;
        logic        sgn, inc, x0, y0, xi, yi, xn, yn;
        logic [2:0]  m;
        logic [47:0] p, rem, half;
        logic [24:0] sig;
        m   = (mode > 3'd4) ? 3'd0 : mode;
        sgn = x[31] ^ y[31];
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        x0  = (ex == 0);
        y0  = (ey == 0);
        xi  = (ex == 255) && (x[22:0] == 0);
        yi  = (ey == 255) && (y[22:0] == 0);
        xn  = (ex == 255) && (x[22:0] != 0);
        yn  = (ey == 255) && (y[22:0] != 0);
        if (xn || yn) return {2'b00, 32'h7FC0_0000};
        if ((xi || yi) && (x0 || y0)) return {2'b00, 32'h7FC0_0000};
        if (xi || yi) return {2'b00, sgn, 31'h7F80_0000};
        if (x0 || y0) return {2'b00, sgn, 31'd0};
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = ex + ey - 127;
        if (p[47]) begin
            e  = e + 1;
            sh = 24;
        end else begin
            sh = 23;
        end
        sig  = 25'(p >> sh);
        rem  = p & ((48'd1 << sh) - 48'd1);
        half = 48'd1 << (sh - 1);
        case (m)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sgn && (rem != 0);
            3'd3:    inc = !sgn && (rem != 0);
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && sig[0]);
        endcase
        sig = sig + 25'(inc);
        if (sig[24]) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) begin
            if (m == 3'd0 || m == 3'd4 || (m == 3'd2 && sgn) || (m == 3'd3 && !sgn))
                return {2'b10, sgn, 31'h7F80_0000};
            return {2'b10, sgn, 31'h7F7F_FFFF};
        end
        if (e <= 0) return {2'b01, sgn, 31'd0};
        return {2'b00, sgn, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          c;
        v = $urandom;
        c = $urandom_range(0, 9);
        case (c)
            0: v[30:23] = 8'h00;
            1: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
            end
            2: ;
            default: begin
                v[30:23] = 8'($urandom_range(97, 157));
                if (c >= 7) v[22:0] = v[22:0] & 23'h7FF000;
            end
        endcase
        return v;
    endfunction

    // Called at a sample point with the DUT idle; returns with out_valid seen high.
    task automatic start_and_wait(input logic [31:0] x, input logic [31:0] y,
                                  input logic [2:0] m, input string tag,
                                  output logic [31:0] z);
        logic [33:0] r;
        int          cyc;
        r = ref_mul(x, y, m);
        check_eq({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fp_X     = $urandom;
        fp_Y     = $urandom;
        r_mode   = 3'($urandom);
        check_eq({tag, "/in_ready_low"}, 64'(in_ready), 64'd0);
        check_eq({tag, "/busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        // cyc+1 is the edge at which out_valid is first sampled high
        check_eq({tag, "/latency"}, 64'(cyc + 1), is_special(x, y) ? 64'd2 : 64'd28);
        check_eq({tag, "/fp_Z"}, 64'(fp_Z), 64'(r[31:0]));
        check_eq({tag, "/ovrf"}, 64'(ovrf), 64'(r[33]));
        check_eq({tag, "/udrf"}, 64'(udrf), 64'(r[32]));
        z = fp_Z;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "/ovalid_drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, "/ready_back"}, 64'(in_ready), 64'd1);
    endtask

    localparam int NDIR = 12;
    logic [31:0] dir_x [NDIR] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                                  32'h7F000000, 32'h7F000000, 32'hFF000000, 32'h7F800000,
                                  32'h00400000, 32'hFF800000, 32'h00800000, 32'h7FC12345};
    logic [31:0] dir_y [NDIR] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                                  32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000,
                                  32'hBF800000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    logic [2:0]  dir_m [NDIR] = '{3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd1, 3'd3, 3'd0,
                                  3'd0, 3'd0, 3'd0, 3'd2};
    logic [31:0] dir_z [NDIR] = '{32'h40400000, 32'h3F800002, 32'h3F800003, 32'h3F800002,
                                  32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FC00000,
                                  32'h80000000, 32'hFF800000, 32'h00000000, 32'h7FC00000};

    initial begin
        logic [31:0] z;
        logic        seen;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset/in_ready", 64'(in_ready), 64'd1);
        check_eq("reset/out_valid", 64'(out_valid), 64'd0);
        check_eq("reset/busy", 64'(busy), 64'd0);
        check_eq("reset/fp_Z", 64'(fp_Z), 64'd0);
        check_eq("reset/flags", 64'({ovrf, udrf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NDIR; i++) begin
            start_and_wait(dir_x[i], dir_y[i], dir_m[i], $sformatf("dir%0d", i), z);
            check_eq($sformatf("dir%0d/table", i), 64'(z), 64'(dir_z[i]));
            handshake($sformatf("dir%0d", i));
        end

        // Hold result in DONE while a new request is offered
        start_and_wait(32'h3FC00000, 32'h40000000, 3'd0, "hold", z);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            fp_X     = 32'h40000000;
            fp_Y     = 32'h40000000;
            @(posedge clk);
            #1;
            check_eq("hold/fp_Z", 64'(fp_Z), 64'h40400000);
            check_eq("hold/in_ready", 64'(in_ready), 64'd0);
            check_eq("hold/out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("hold/no_accept_on_hs", 64'(busy), 64'd0);
        check_eq("hold/idle_keeps_z", 64'(fp_Z), 64'h40400000);

        // Reset during MUL discards the pending result
        start_and_wait(32'h3FC00000, 32'h40000000, 3'd0, "pre_rst", z);
        handshake("pre_rst");
        fp_X     = 32'h3FC00000;
        fp_Y     = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst/out_valid", 64'(out_valid), 64'd0);
        check_eq("rst/in_ready", 64'(in_ready), 64'd1);
        check_eq("rst/fp_Z", 64'(fp_Z), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("rst/no_result", 64'(seen), 64'd0);

        for (int i = 0; i < 150; i++) begin
            start_and_wait(rand_op(), rand_op(), 3'($urandom_range(0, 7)),
                           $sformatf("rnd%0d", i), z);
            handshake($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
